// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the IF stage (master)
// and the instruction memory (slave).
interface fetch_stage_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;

  modport master (output im_req, im_addr, input im_ack, im_rdata);
  modport slave  (input im_req, im_addr, output im_ack, im_rdata);
endinterface

// File: rtl/fetch_stage.sv
// IF stage of the pipelined MIPS core: PC register, variable-latency fetch, IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds the perf_wait_cycles memory-wait counter.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_6ffc
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   npc,
  input  logic          stall,
  input  logic          flush,
  output logic [31:0]   F_pc,
  fetch_stage_if.master im,
  output logic [31:0]   D_pc,
  output logic [31:0]   D_instr,
  output logic [4:0]    D_excCode,
  output logic          D_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   perf_wait_cycles
`endif
);

  typedef enum logic [1:0] {ISSUE, HOLD, DISCARD} state_t;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  state_t      state, state_next;
  logic [31:0] hold_instr;
  logic [4:0]  hold_exc;
  logic [31:0] stale_addr;
  logic        legal;
  logic        ready;
  logic        outstanding;
  logic [31:0] ready_instr;
  logic [4:0]  ready_exc;

  always_comb begin
    legal       = (F_pc[1:0] == 2'b00) && (F_pc >= IM_BASE) && (F_pc <= IM_LIMIT);
    im.im_req   = ((state == ISSUE) && legal) || (state == DISCARD);
    im.im_addr  = (state == DISCARD) ? stale_addr : F_pc;
    outstanding = im.im_req && !im.im_ack;
    ready       = ((state == ISSUE) && (im.im_ack || !legal)) || (state == HOLD);
    ready_instr = im.im_rdata;
    ready_exc   = EXC_NONE;
    if (state == HOLD) begin
      ready_instr = hold_instr;
      ready_exc   = hold_exc;
    end else if (!legal) begin
      ready_instr = 32'd0;
      ready_exc   = EXC_ADEL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ISSUE;
    else       state <= state_next;
  end

  // A flush during an in-flight fetch must still wait out that fetch's ack.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = outstanding ? DISCARD : ISSUE;
    end else begin
      case (state)
        ISSUE:   if (ready && stall) state_next = HOLD;
        HOLD:    if (!stall)         state_next = ISSUE;
        DISCARD: if (im.im_ack)      state_next = ISSUE;
        default:                     state_next = ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      F_pc       <= RESET_PC;
      D_pc       <= 32'd0;
      D_instr    <= 32'd0;
      D_excCode  <= EXC_NONE;
      D_valid    <= 1'b0;
      hold_instr <= 32'd0;
      hold_exc   <= EXC_NONE;
      stale_addr <= 32'd0;
    end else if (flush) begin
      D_instr    <= 32'd0;
      D_excCode  <= EXC_NONE;
      D_valid    <= 1'b0;
      F_pc       <= npc;
      stale_addr <= im.im_addr;
    end else begin
      case (state)
        ISSUE: begin
          if (ready && !stall) begin
            D_pc      <= F_pc;
            D_instr   <= ready_instr;
            D_excCode <= ready_exc;
            D_valid   <= 1'b1;
            F_pc      <= npc;
          end else if (ready) begin
            hold_instr <= ready_instr;
            hold_exc   <= ready_exc;
          end else if (!stall) begin
            D_instr   <= 32'd0;
            D_excCode <= EXC_NONE;
            D_valid   <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            D_pc      <= F_pc;
            D_instr   <= hold_instr;
            D_excCode <= hold_exc;
            D_valid   <= 1'b1;
            F_pc      <= npc;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Counts only real fetch waits; draining a discarded request is not charged.
  always_ff @(posedge clk) begin
    if (reset)
      perf_wait_cycles <= 32'd0;
    else if ((state == ISSUE) && im.im_req && !im.im_ack && (perf_wait_cycles != 32'hffff_ffff))
      perf_wait_cycles <= perf_wait_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: wait-state memory model, IF/ID scoreboard
// and directed checks of the request/hold/discard behaviour.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] npc;
  logic [31:0] F_pc;
  logic [31:0] D_pc;
  logic [31:0] D_instr;
  logic [4:0]  D_excCode;
  logic        D_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_wait_cycles;
`endif

  fetch_stage_if im ();

  logic        npc_force_en;
  logic [31:0] npc_force_val;
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [68:0] exp_q[$];
  logic [68:0] exp_entry;
  logic        stall_seen;
  logic        reset_seen;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .npc              (npc),
    .stall            (stall),
    .flush            (flush),
    .F_pc             (F_pc),
    .im               (im.master),
    .D_pc             (D_pc),
    .D_instr          (D_instr),
    .D_excCode        (D_excCode),
    .D_valid          (D_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_wait_cycles (perf_wait_cycles)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Next-PC logic stand-in: sequential unless the stimulus forces a target.
  assign npc         = npc_force_en ? npc_force_val : F_pc + 32'd4;
  assign im.im_ack   = im.im_req && (wait_cnt == wait_cfg);
  assign im.im_rdata = mem_word(im.im_addr);

  always @(posedge clk) begin
    if (reset || !im.im_req || im.im_ack) wait_cnt <= 0;
    else                                  wait_cnt <= wait_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic stl, input logic fl,
                               input logic force_en, input logic [31:0] force_val);
    reset         = rst;
    stall         = stl;
    flush         = fl;
    npc_force_en  = force_en;
    npc_force_val = force_val;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] exc);
    exp_q.push_back({pc, instr, exc});
  endtask

  // A new IF/ID entry appears on any non-reset, non-stalled edge that leaves D_valid high.
  always begin
    @(posedge clk);
    stall_seen = stall;
    reset_seen = reset;
    #1;
    if (!reset_seen && !stall_seen && D_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("D_valid_unexpected", {31'd0, D_valid}, 32'd0);
      end else begin
        exp_entry = exp_q.pop_front();
        checkOutput("sb_D_pc",      D_pc,               exp_entry[68:37]);
        checkOutput("sb_D_instr",   D_instr,            exp_entry[36:5]);
        checkOutput("sb_D_excCode", {27'd0, D_excCode}, {27'd0, exp_entry[4:0]});
      end
    end
  end

  initial begin
    logic [31:0] bad_pc [2];
    bad_pc[0] = 32'h0000_3002;
    bad_pc[1] = 32'h0000_7000;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    wait_cfg = 0;
    step(3);
    checkOutput("rst_F_pc",      F_pc,               32'h0000_3000);
    checkOutput("rst_D_pc",      D_pc,               32'd0);
    checkOutput("rst_D_instr",   D_instr,            32'd0);
    checkOutput("rst_D_excCode", {27'd0, D_excCode}, 32'd0);
    checkOutput("rst_D_valid",   {31'd0, D_valid},   32'd0);
    checkOutput("rst_im_req",    {31'd0, im.im_req}, 32'd1);
    checkOutput("rst_im_addr",   im.im_addr,         32'h0000_3000);

    // Zero-wait streaming: one instruction per cycle.
    for (int i = 0; i < 3; i++) push_exp(32'h3000 + 32'(4 * i), mem_word(32'h3000 + 32'(4 * i)), 5'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      checkOutput("stream_D_pc",    D_pc,             32'h3000 + 32'(4 * i));
      checkOutput("stream_D_valid", {31'd0, D_valid}, 32'd1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    wait_cfg = 2;
    step(2);

    // Two-wait fetch, then a stall landing on the ack cycle of the next fetch.
    push_exp(32'h3000, mem_word(32'h3000), 5'd0);
    push_exp(32'h3004, mem_word(32'h3004), 5'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("wait_im_req",  {31'd0, im.im_req}, 32'd1);
      checkOutput("wait_im_addr", im.im_addr,         32'h3000);
      if (i > 0) checkOutput("wait_D_valid", {31'd0, D_valid}, 32'd0);
      step(1);
    end
    checkOutput("wait_D_pc", D_pc, 32'h3000);
    step(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      checkOutput("hold_im_req", {31'd0, im.im_req}, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1);
    checkOutput("hold_D_pc",    D_pc,    32'h3004);
    checkOutput("hold_D_instr", D_instr, mem_word(32'h3004));
    checkOutput("hold_F_pc",    F_pc,    32'h3008);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    wait_cfg = 0;
    step(2);

    // Misaligned and out-of-range targets must be tagged AdEL without a request.
    for (int k = 0; k < 2; k++) begin
      push_exp(32'h3000, mem_word(32'h3000), 5'd0);
      push_exp(bad_pc[k], 32'd0, 5'd4);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, bad_pc[k]);
      step(1);
      checkOutput("bad_F_pc",   F_pc,               bad_pc[k]);
      checkOutput("bad_im_req", {31'd0, im.im_req}, 32'd0);
      step(1);
      checkOutput("bad_D_pc",      D_pc,               bad_pc[k]);
      checkOutput("bad_D_excCode", {27'd0, D_excCode}, 32'd4);
      checkOutput("bad_D_valid",   {31'd0, D_valid},   32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      step(2);
    end

    // Flush while a 3-wait fetch of 0x3010 is in flight.
    push_exp(32'h3000, mem_word(32'h3000), 5'd0);
    push_exp(32'h4180, mem_word(32'h4180), 5'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h3010);
    step(1);
    wait_cfg = 3;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h4180);
    step(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("flush_im_req",  {31'd0, im.im_req}, 32'd1);
    checkOutput("flush_im_addr", im.im_addr,         32'h3010);
    checkOutput("flush_F_pc",    F_pc,               32'h4180);
    checkOutput("flush_D_valid", {31'd0, D_valid},   32'd0);
    step(1);
    checkOutput("discard_im_addr", im.im_addr, 32'h3010);
    step(1);
    checkOutput("refetch_im_req",  {31'd0, im.im_req}, 32'd1);
    checkOutput("refetch_im_addr", im.im_addr,         32'h4180);
    step(4);
    checkOutput("refetch_D_pc", D_pc, 32'h4180);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    wait_cfg = 2;
    step(2);

    // Four two-wait fetches back to back.
    for (int i = 0; i < 4; i++) push_exp(32'h3000 + 32'(4 * i), mem_word(32'h3000 + 32'(4 * i)), 5'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("perf_reset", perf_wait_cycles, 32'd0);
`endif
    step(12);
    checkOutput("burst_D_pc", D_pc, 32'h300c);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("perf_wait_cycles", perf_wait_cycles, 32'd8);
`endif
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    step(2);

    checkOutput("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the pipelined MIPS core.
- Owns the PC register and issues instruction fetches over a variable-latency req/ack instruction-memory port.
- Loads the IF/ID pipeline register (D_*) and exports F_pc to the next-PC logic, which returns npc.
- Detects illegal fetch addresses and tags them with AdEL instead of fetching.

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset
IM_BASE, 32'h0000_3000, lowest legal fetch address
IM_LIMIT, 32'h0000_6ffc, highest legal fetch address (inclusive)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
npc  in  32  next PC from next-PC logic, valid every cycle
stall  in  1  hazard-unit stall: freeze F_pc and D_* registers
flush  in  1  redirect (exception/eret): bubble D_*, F_pc <= npc
F_pc  out  32  current fetch PC, to next-PC logic
im_req  out  1  fetch request to instruction memory
im_addr  out  32  fetch address; equals F_pc while im_req=1, except in DISCARD
im_ack  in  1  fetch completes this cycle; im_rdata valid
im_rdata  in  32  fetched instruction
D_pc  out  32  PC of the instruction in the IF/ID register
D_instr  out  32  instruction in the IF/ID register; 0 (nop) for a bubble
D_excCode  out  5  0 = none, 5'd4 = AdEL
D_valid  out  1  1 = real instruction, 0 = bubble

Behaviour:
- Reset values: F_pc=RESET_PC, D_pc=0, D_instr=0, D_excCode=0, D_valid=0, state=ISSUE, hold buffer=0.
- Legality check: legal = (F_pc[1:0]==0) && IM_BASE<=F_pc<=IM_LIMIT, using unsigned compare.
- "Ready" condition, combinational, for the instruction at F_pc:
  - (ISSUE && im_ack), or (ISSUE && !legal), or HOLD.
  - In the !legal case the instruction is 0 with excCode 4. Otherwise it is im_rdata, or the hold buffer when in HOLD, with excCode 0.
- im_req = state==ISSUE && legal, or state==DISCARD. Illegal PCs never reach memory.
- Once im_req rises, im_req and im_addr stay stable until im_ack, including across stall.
- In DISCARD, im_addr keeps the stale address latched at flush time.
- ISSUE:
  - ready && !stall && !flush: D_* <= {F_pc, instr, exc, 1}; F_pc <= npc; stay in ISSUE. Best case is 1 instruction/cycle with 0-wait memory.
  - ready && stall: latch instr/exc into the hold buffer; go to HOLD; F_pc and D_* unchanged.
  - !ready && !stall: D_* <= bubble (D_instr=0, D_valid=0, D_excCode=0; D_pc unchanged); F_pc held.
  - !ready && stall: everything held.
- HOLD: no request. When !stall, load D_* from the hold buffer, F_pc <= npc, go to ISSUE.
- flush has priority over stall and ready, and acts in any state:
  - D_* <= bubble; F_pc <= npc.
  - If a request is outstanding (im_req=1 && !im_ack): go to DISCARD, else go to ISSUE.
- DISCARD: keep the stale request asserted. On im_ack, drop the data and go to ISSUE. D_* stays bubble.
- Reset mid-request forces ISSUE; the memory model must also drop its pending request on reset.
- PC arithmetic is 32-bit with no wrap check. A wrapped PC is simply illegal.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds output perf_wait_cycles[31:0], reset 0. It increments each cycle state==ISSUE && im_req && !im_ack (DISCARD cycles excluded) and saturates at 32'hffff_ffff.
- Undefined: the port and its counter do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset, 0-wait memory (im_ack same cycle), npc=F_pc+4, no stall:
  - D_pc sequence 0x3000, 0x3004, 0x3008 on consecutive cycles; D_valid=1.
- 2-wait memory at 0x3000:
  - im_req=1, im_addr=0x3000 held 3 cycles; D_valid=0 for 2 cycles, then D_instr=im_rdata, D_pc=0x3000.
- stall=1 in the ack cycle for 0x3004, held 3 cycles:
  - state HOLD, im_req=0; on release D_pc=0x3004 with the buffered instr; F_pc advances to 0x3008.
- npc=0x3002 (misaligned) and separately npc=0x7000 (out of range):
  - no im_req; next cycle D_pc=that PC, D_instr=0, D_excCode=4, D_valid=1.
- flush with npc=0x4180 while a 3-wait request for 0x3010 is outstanding:
  - D bubble; im_addr stays 0x3010 until ack; that data never appears on D; next fetch im_addr=0x4180.
- FETCH_PERF_CNT_EN defined, 2-wait fetches of 4 instructions:
  - perf_wait_cycles=8.
